// File: rtl/adder_stream_arbiter.sv
// -----------------------------------------------------------------------------
// adder_stream_arbiter
//
// Lets NUM_REQ requester AXI-Stream sources share the single AXI-Stream input
// of the adder. Requesters are served round-robin. Once a requester is granted,
// it keeps the grant until its tlast beat is accepted. The adder-side signals
// come straight from a register stage, so tvalid/tdata/tlast are glitch-free.
//
// Ports
//   clk, rst                     : clock, asynchronous active-high reset
//   s_axis_tvalid/tlast [NUM_REQ]: per-requester valid / last-beat flag
//   s_axis_tdata [NUM_REQ*DATAW] : requester i at [i*DATAW +: DATAW]
//   s_axis_tready [NUM_REQ]      : per-requester ready (one-hot or zero)
//   axis_adder_interface_*       : registered stream towards the adder
//   grant_id                     : current / most recent granted requester
//   busy                         : a packet is in progress (LOCKED)
// -----------------------------------------------------------------------------
module adder_stream_arbiter #(
  parameter  int DATAW   = 128,
  parameter  int NUM_REQ = 4,
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         s_axis_tvalid,
  input  logic [NUM_REQ-1:0]         s_axis_tlast,
  input  logic [NUM_REQ*DATAW-1:0]   s_axis_tdata,
  output logic [NUM_REQ-1:0]         s_axis_tready,
  output logic                       axis_adder_interface_tvalid,
  output logic                       axis_adder_interface_tlast,
  output logic [DATAW-1:0]           axis_adder_interface_tdata,
  input  logic                       axis_adder_interface_tready,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GRANT_W-1:0]  r_grant;
  logic [GRANT_W-1:0]  r_last_grant;
  logic [GRANT_W-1:0]  w_pick;

  logic                r_tvalid;
  logic                r_tlast;
  logic [DATAW-1:0]    r_tdata;

  logic                w_load_ok;
  logic                w_sel_valid;
  logic                w_beat_last;
  logic [DATAW-1:0]    w_beat_data;
  logic [NUM_REQ-1:0]  w_tready;
  logic                w_accept;

  // Round-robin pick: the lowest requesting index above 'last' wins; if none
  // is above, wrap and take the lowest requesting index at or below 'last'.
  function automatic logic [GRANT_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [GRANT_W-1:0] last
  );
    logic [GRANT_W-1:0] pick;
    pick = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j <= int'(last))) pick = GRANT_W'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last))) pick = GRANT_W'(j);
    end
    return pick;
  endfunction

  assign w_pick = rr_pick(s_axis_tvalid, r_last_grant);

  // Granted-requester mux and ready generation. Ready depends only on the FSM
  // state and whether the output register can take a beat, never on tvalid.
  always_comb begin
    w_load_ok   = !r_tvalid || axis_adder_interface_tready;
    w_sel_valid = 1'b0;
    w_beat_last = 1'b0;
    w_beat_data = '0;
    w_tready    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant == GRANT_W'(j)) begin
        w_sel_valid = s_axis_tvalid[j];
        w_beat_last = s_axis_tlast[j];
        w_beat_data = s_axis_tdata[j*DATAW +: DATAW];
        if (r_state == ST_LOCKED) w_tready[j] = w_load_ok;
      end
    end
    w_accept = (r_state == ST_LOCKED) && w_load_ok && w_sel_valid;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|s_axis_tvalid) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept && w_beat_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- arbitration state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (|s_axis_tvalid)) r_grant <= w_pick;
      if (w_accept && w_beat_last) r_last_grant <= r_grant;
    end
  end

  // ---- output register towards the adder ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_beat_last;
      r_tdata  <= w_beat_data;
    end else if (axis_adder_interface_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready               = w_tready;
  assign axis_adder_interface_tvalid = r_tvalid;
  assign axis_adder_interface_tlast  = r_tlast;
  assign axis_adder_interface_tdata  = r_tdata;
  assign grant_id                    = r_grant;
  assign busy                        = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_stream_arbiter
//
// Directed bench for adder_stream_arbiter (DATAW=128, NUM_REQ=4). Each
// requester has a beat queue served by a small AXI-Stream source process.
// Expected adder beats are pushed into a scoreboard queue; a monitor pops and
// compares every beat the adder accepts, recording the cycle it was seen.
// -----------------------------------------------------------------------------
module tb_adder_stream_arbiter;

  localparam int DATAW   = 128;
  localparam int NREQ    = 4;
  localparam int GRANT_W = 2;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         s_axis_tvalid;
  logic [NREQ-1:0]         s_axis_tlast;
  logic [NREQ*DATAW-1:0]   s_axis_tdata;
  logic [NREQ-1:0]         s_axis_tready;
  logic                    ad_tvalid;
  logic                    ad_tlast;
  logic [DATAW-1:0]        ad_tdata;
  logic                    ad_tready;
  logic [GRANT_W-1:0]      grant_id;
  logic                    busy;

  adder_stream_arbiter #(.DATAW(DATAW), .NUM_REQ(NREQ)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .s_axis_tvalid               (s_axis_tvalid),
    .s_axis_tlast                (s_axis_tlast),
    .s_axis_tdata                (s_axis_tdata),
    .s_axis_tready               (s_axis_tready),
    .axis_adder_interface_tvalid (ad_tvalid),
    .axis_adder_interface_tlast  (ad_tlast),
    .axis_adder_interface_tdata  (ad_tdata),
    .axis_adder_interface_tready (ad_tready),
    .grant_id                    (grant_id),
    .busy                        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DATAW:0] rq [NREQ][$];   // {tlast, tdata} per requester
  logic [DATAW:0] exp_q [$];
  int             out_cyc [$];

  task automatic chk(input string nm, input logic [DATAW:0] act, input logic [DATAW:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_gap(input string nm, input int a, input int b, input int req);
    if (out_cyc.size() > b) chk_int(nm, out_cyc[b] - out_cyc[a], req);
    else                    chk_int(nm, -1, req);
  endtask

  function automatic logic [DATAW:0] beat(input logic last, input logic [DATAW-1:0] d);
    return {last, d};
  endfunction

  // Requester sources: present the head of each queue, retire it once the
  // beat was seen with tvalid && tready just before the rising edge.
  initial begin
    logic [NREQ-1:0] acc;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && (rq[i].size() > 0)) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          s_axis_tvalid[i]               = 1'b1;
          s_axis_tlast[i]                = rq[i][0][DATAW];
          s_axis_tdata[i*DATAW +: DATAW] = rq[i][0][DATAW-1:0];
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [DATAW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ad_tvalid && ad_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", {ad_tlast, ad_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("adder_beat", {ad_tlast, ad_tdata}, e);
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    chk_int(nm, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_out(input string nm, input logic [DATAW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ad_tvalid && (ad_tdata == d)) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    chk_int(nm, int'(ad_tvalid && (ad_tdata == d)), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    ad_tready = 1'b1;

    // ---------------- reset state
    #12;
    chk("rst_tvalid", ad_tvalid, 0);
    chk("rst_tlast", ad_tlast, 0);
    chk("rst_tdata", ad_tdata, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- single requester, 3 beats
    out_cyc.delete();
    rq[0].push_back(beat(0, 128'h1)); exp_q.push_back(beat(0, 128'h1));
    rq[0].push_back(beat(0, 128'h2)); exp_q.push_back(beat(0, 128'h2));
    rq[0].push_back(beat(1, 128'h3)); exp_q.push_back(beat(1, 128'h3));
    wait_out("t1_see3", 128'h3);
    chk("t1_tlast3", ad_tlast, 1);
    chk("t1_busy_drop", busy, 0);
    chk("t1_grant", grant_id, 0);
    wait_drain("t1_drain");
    chk_gap("t1_gap01", 0, 1, 1);
    chk_gap("t1_gap12", 1, 2, 1);

    // ---------------- round-robin, all four requesters, two packets each
    do_reset();
    out_cyc.delete();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        rq[i].push_back(beat(1, 128'hA0 + 128'(i)));
        exp_q.push_back(beat(1, 128'hA0 + 128'(i)));
      end
    end
    wait_drain("rr_drain");
    for (int i = 1; i < 8; i++) chk_gap("rr_gap", i - 1, i, 2);

    // ---------------- packet lock: req 2 three beats, req 0 arrives mid-packet
    out_cyc.delete();
    rq[2].push_back(beat(0, 128'h21)); exp_q.push_back(beat(0, 128'h21));
    rq[2].push_back(beat(0, 128'h22)); exp_q.push_back(beat(0, 128'h22));
    rq[2].push_back(beat(1, 128'h23)); exp_q.push_back(beat(1, 128'h23));
    n = 0;
    @(negedge clk);
    while (!(busy && (grant_id == 2'd2)) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    chk("lk_grant2", grant_id, 2);
    rq[0].push_back(beat(1, 128'h01)); exp_q.push_back(beat(1, 128'h01));
    n = 0;
    while ((rq[2].size() > 0) && (n < 50)) begin
      chk("lk_sready0", s_axis_tready[0], 0);
      @(negedge clk);
      n++;
    end
    wait_drain("lk_drain");
    chk_gap("lk_gap01", 0, 1, 1);
    chk_gap("lk_gap12", 1, 2, 1);
    chk_gap("lk_gap23", 2, 3, 2);
    chk("lk_grant0", grant_id, 0);

    // ---------------- backpressure: adder stalls with 0x55 held
    out_cyc.delete();
    @(posedge clk);
    #1;
    ad_tready = 1'b0;
    rq[1].push_back(beat(0, 128'h55)); exp_q.push_back(beat(0, 128'h55));
    rq[1].push_back(beat(1, 128'h56)); exp_q.push_back(beat(1, 128'h56));
    wait_out("bp_see55", 128'h55);
    for (int k = 0; k < 4; k++) begin
      chk("bp_tdata", ad_tdata, 128'h55);
      chk("bp_tvalid", ad_tvalid, 1);
      chk("bp_sready", s_axis_tready, 0);
      @(negedge clk);
    end
    chk("bp_grant", grant_id, 1);
    @(posedge clk);
    #1;
    ad_tready = 1'b1;
    wait_drain("bp_drain");
    chk_gap("bp_gap", 0, 1, 1);

    // ---------------- asynchronous reset during beat 2 of 3
    rq[0].push_back(beat(0, 128'h71)); exp_q.push_back(beat(0, 128'h71));
    rq[0].push_back(beat(0, 128'h72)); exp_q.push_back(beat(0, 128'h72));
    rq[0].push_back(beat(1, 128'h73)); exp_q.push_back(beat(1, 128'h73));
    wait_out("ar_see71", 128'h71);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    #1;
    chk("ar_tvalid", ad_tvalid, 0);
    chk("ar_tlast", ad_tlast, 0);
    chk("ar_tdata", ad_tdata, 0);
    chk("ar_sready", s_axis_tready, 0);
    chk("ar_busy", busy, 0);
    chk("ar_grant", grant_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", busy, 0);
    rq[2].push_back(beat(1, 128'h82));
    rq[0].push_back(beat(1, 128'h80));
    exp_q.push_back(beat(1, 128'h80));
    exp_q.push_back(beat(1, 128'h82));
    wait_drain("ar_drain");

    // ---------------- wrap-around: bring last_grant to 3, then reqs 1 and 3
    rq[3].push_back(beat(1, 128'h93)); exp_q.push_back(beat(1, 128'h93));
    wait_drain("wr_prep");
    rq[1].push_back(beat(1, 128'h91));
    rq[3].push_back(beat(1, 128'h94));
    exp_q.push_back(beat(1, 128'h91));
    exp_q.push_back(beat(1, 128'h94));
    wait_drain("wr_drain");
    chk("wr_grant", grant_id, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
